// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: op field codes, FSM states and
// small decode helpers used by lsu_ctrl and lsu_lane.
package lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam int         OP_STORE_BIT = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic op_is_byte(input logic [2:0] sz);
    return (sz == OP_B) || (sz == OP_BU);
  endfunction

  function automatic logic op_is_half(input logic [2:0] sz);
    return (sz == OP_H) || (sz == OP_HU);
  endfunction

  function automatic logic op_is_sub_word(input logic [2:0] sz);
    return op_is_byte(sz) || op_is_half(sz);
  endfunction

  // Unlisted size codes behave as words, so they need full word alignment.
  function automatic logic op_misaligned(input logic [2:0] sz, input logic [1:0] lo);
    if (op_is_byte(sz))
      return 1'b0;
    else if (op_is_half(sz))
      return lo[0];
    else
      return lo != 2'b00;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts and extends a load result from the read
// word, and merges byte/halfword store data into the read word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  lane_sel,
  input  logic [31:0] rd_word,
  input  logic [15:0] st_data,
  output logic [31:0] ld_ext,
  output logic [31:0] st_merge
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[{lane_sel, 3'b000} +: 8];
    half_sel = lane_sel[1] ? rd_word[31:16] : rd_word[15:0];

    case (size)
      OP_B:    ld_ext = 32'(byte_sel);
      OP_BU:   ld_ext = {24'd0, byte_sel};
      OP_H:    ld_ext = 32'(half_sel);
      OP_HU:   ld_ext = {16'd0, half_sel};
      default: ld_ext = rd_word;
    endcase

    // Lanes not addressed by the store keep the value just read.
    st_merge = rd_word;
    if (op_is_byte(size))
      st_merge[{lane_sel, 3'b000} +: 8] = st_data[7:0];
    else if (op_is_half(size))
      st_merge[{lane_sel[1], 4'b0000} +: 16] = st_data;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a word-addressed data memory: IDLE/RD/WR/DONE FSM
// with read-modify-write for SB/SH. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int WORD_ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [3:0]  lsu_op,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_misalign,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [15:0] wdata_q;
  logic [31:0] word_addr_in;
  logic [31:0] ld_ext;
  logic [31:0] st_merge;
  logic        accept;
  logic        unused_addr_hi;

  assign accept         = (state == S_IDLE) && lsu_req_valid;
  assign word_addr_in   = 32'(lsu_addr[WORD_ADDR_BITS+1:2]);
  // Address bits above the window alias onto it by design.
  assign unused_addr_hi = ^lsu_addr[31:WORD_ADDR_BITS+2];

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_in;
  assign misalign_in = op_misaligned(lsu_op[2:0], lsu_addr[1:0]);
`endif

  lsu_lane u_lane (
    .size     (op_q[2:0]),
    .lane_sel (addr_lo_q),
    .rd_word  (DMEM_data_out),
    .st_data  (wdata_q),
    .ld_ext   (ld_ext),
    .st_merge (st_merge)
  );

  // Request capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q      <= lsu_op;
      addr_lo_q <= lsu_addr[1:0];
      wdata_q   <= lsu_wdata[15:0];
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      lsu_req_ready  <= 1'b1;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= 32'd0;
      lsu_misalign   <= 1'b0;
      DMEM_address   <= 32'd0;
      DMEM_data_in   <= 32'd0;
      DMEM_mem_write <= 1'b0;
      DMEM_mem_read  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu_req_valid) begin
            lsu_req_ready <= 1'b0;
            DMEM_address  <= word_addr_in;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misalign_in) begin
              state          <= S_DONE;
              lsu_resp_valid <= 1'b1;
              lsu_rdata      <= 32'd0;
              lsu_misalign   <= 1'b1;
            end else
`endif
            if (lsu_op[OP_STORE_BIT] && !op_is_sub_word(lsu_op[2:0])) begin
              state          <= S_WR;
              DMEM_mem_write <= 1'b1;
              DMEM_data_in   <= lsu_wdata;
            end else begin
              state         <= S_RD;
              DMEM_mem_read <= 1'b1;
            end
          end
        end
        S_RD: begin
          DMEM_mem_read <= 1'b0;
          if (op_q[OP_STORE_BIT]) begin
            state          <= S_WR;
            DMEM_mem_write <= 1'b1;
            DMEM_data_in   <= st_merge;
          end else begin
            state          <= S_DONE;
            lsu_resp_valid <= 1'b1;
            lsu_rdata      <= ld_ext;
            lsu_misalign   <= 1'b0;
          end
        end
        S_WR: begin
          DMEM_mem_write <= 1'b0;
          state          <= S_DONE;
          lsu_resp_valid <= 1'b1;
          lsu_rdata      <= 32'd0;
          lsu_misalign   <= 1'b0;
        end
        default: begin
          state          <= S_IDLE;
          lsu_resp_valid <= 1'b0;
          lsu_misalign   <= 1'b0;
          lsu_req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
